// File: rtl/branch_pred_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_pred_ctrl
// Description : Branch-direction predictor (2-bit saturating BHT) and
//               mispredict-recovery sequencer for a 5-stage core. Predicts
//               in IF, trains and detects mispredicts in EX, sequences the
//               PC redirect and the IF/ID, ID/EX flushes, and keeps
//               saturating branch / mispredict statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_pred_ctrl #(
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    // IF-stage prediction interface
    input  logic             if_valid,
    input  logic             if_is_branch,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    // EX-stage resolution interface
    input  logic             ex_valid,
    input  logic [3:0]       ex_bj_inst,
    input  logic             ex_branch,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    // Recovery controls
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    // Statistics
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [1:0]       C_CNT_WNT = 2'b01;
    localparam logic [1:0]       C_CNT_MAX = 2'b11;
    localparam logic [1:0]       C_CNT_MIN = 2'b00;
    localparam logic [CNT_W-1:0] C_STAT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [1:0]        bht_q [BHT_ENTRIES];
    logic              redirect_q;
    logic              flush_if_id_q;
    logic              flush_id_ex_q;
    logic [31:0]       redirect_pc_q;
    logic [CNT_W-1:0]  branch_cnt_q;
    logic [CNT_W-1:0]  mispred_cnt_q;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  if_idx;
    logic [IDX_W-1:0]  ex_idx;
    logic              is_br;
    logic              res;
    logic              mis;
    logic [1:0]        bht_cur;
    logic [1:0]        bht_d;
    logic [31:0]       redirect_pc_d;
    logic              unused_pc_bits;

    // Word-aligned PCs: bits [1:0] never select a table entry.
    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0],
                              ex_pc[31:IDX_W+2], ex_pc[1:0]};

    // Conditional-branch codes are 1000, 1001 and 11xx; 1010/1011 are
    // jumps and 0xxx is non-control, so neither trains nor counts.
    assign is_br = ex_bj_inst[3] & (ex_bj_inst[2] | ~ex_bj_inst[1]);

    // Resolutions are only honoured in IDLE; while flushing, EX holds a
    // wrong-path instruction.
    assign res = ex_valid & is_br & ~stall & (state_q == ST_IDLE);
    assign mis = res & (ex_branch != ex_pred_taken);

    // Prediction reads the registered table only, so a same-cycle
    // training write is not visible until the following cycle.
    assign pred_taken = if_valid & if_is_branch & bht_q[if_idx][1];

    // Saturating +1/-1 of the counter being trained.
    assign bht_cur = bht_q[ex_idx];
    always_comb begin
        bht_d = bht_cur;
        if (ex_branch) begin
            if (bht_cur != C_CNT_MAX) begin
                bht_d = bht_cur + 2'd1;
            end
        end else begin
            if (bht_cur != C_CNT_MIN) begin
                bht_d = bht_cur - 2'd1;
            end
        end
    end

    // Corrected fetch address; the +4 path wraps naturally at 2^32.
    assign redirect_pc_d = ex_branch ? ex_target : (ex_pc + 32'd4);

    // ------------------------------------------------------------------
    // BHT storage: all counters start weakly not-taken.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= C_CNT_WNT;
            end
        end else if (res) begin
            bht_q[ex_idx] <= bht_d;
        end
    end

    // ------------------------------------------------------------------
    // Recovery FSM with registered redirect/flush outputs. A stalled
    // FLUSH holds everything so the redirect cannot be dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            redirect_q    <= 1'b0;
            flush_if_id_q <= 1'b0;
            flush_id_ex_q <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mis) begin
                        state_q       <= ST_FLUSH;
                        redirect_q    <= 1'b1;
                        flush_if_id_q <= 1'b1;
                        flush_id_ex_q <= 1'b1;
                        redirect_pc_q <= redirect_pc_d;
                    end else begin
                        redirect_q    <= 1'b0;
                        flush_if_id_q <= 1'b0;
                        flush_id_ex_q <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (!stall) begin
                        state_q       <= ST_IDLE;
                        redirect_q    <= 1'b0;
                        flush_if_id_q <= 1'b0;
                        flush_id_ex_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    redirect_q    <= 1'b0;
                    flush_if_id_q <= 1'b0;
                    flush_id_ex_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating statistics counters.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (res && (branch_cnt_q != C_STAT_MAX)) begin
                branch_cnt_q <= branch_cnt_q + 1'b1;
            end
            if (mis && (mispred_cnt_q != C_STAT_MAX)) begin
                mispred_cnt_q <= mispred_cnt_q + 1'b1;
            end
        end
    end

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign flush_if_id = flush_if_id_q;
    assign flush_id_ex = flush_id_ex_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_pred_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_pred_ctrl
// Description : Scoreboard bench for branch_pred_ctrl. Stimulus pushes one
//               expected redirect address per expected redirect cycle; a
//               monitor pops and compares whenever recovery outputs assert.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_pred_ctrl;

    localparam int BHT_ENTRIES = 64;
    localparam int CNT_W       = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall;
    logic             if_valid;
    logic             if_is_branch;
    logic [31:0]      if_pc;
    logic             pred_taken;
    logic             ex_valid;
    logic [3:0]       ex_bj_inst;
    logic             ex_branch;
    logic             ex_pred_taken;
    logic [31:0]      ex_pc;
    logic [31:0]      ex_target;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    branch_pred_ctrl #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .if_valid      (if_valid),
        .if_is_branch  (if_is_branch),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .ex_valid      (ex_valid),
        .ex_bj_inst    (ex_bj_inst),
        .ex_branch     (ex_branch),
        .ex_pred_taken (ex_pred_taken),
        .ex_pc         (ex_pc),
        .ex_target     (ex_target),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every cycle with recovery outputs asserted consumes one
    // expected redirect address.
    always @(negedge clk) begin
        if (redirect || flush_if_id || flush_id_ex) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_redirect: got redir=%b fifd=%b fide=%b pc=%h expected no redirect",
                         redirect, flush_if_id, flush_id_ex, redirect_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (!(redirect && flush_if_id && flush_id_ex) || redirect_pc !== e) begin
                    errors++;
                    $display("FAIL redirect_cycle: got redir=%b fifd=%b fide=%b pc=%h expected 1 1 1 pc=%h",
                             redirect, flush_if_id, flush_id_ex, redirect_pc, e);
                end
            end
        end
    end

    // Issue one EX resolution starting at posedge+1; waits out the flush
    // cycle of an expected mispredict. pchk>=0 checks pred_taken during
    // the training cycle itself.
    task automatic issue(input logic [31:0] pc, input logic br, input logic pt,
                         input logic [31:0] tgt, input logic [3:0] code, input int pchk);
        logic isb;
        logic m;
        ex_pc         = pc;
        ex_branch     = br;
        ex_pred_taken = pt;
        ex_target     = tgt;
        ex_bj_inst    = code;
        ex_valid      = 1'b1;
        isb = (code == 4'b1000) || (code == 4'b1001) || (code == 4'b1100) ||
              (code == 4'b1101) || (code == 4'b1110) || (code == 4'b1111);
        m = isb && !stall && (br != pt);
        if (m) exp_q.push_back(br ? tgt : pc + 32'd4);
        if (pchk >= 0) begin
            #1;
            chk("pred_no_bypass", {31'd0, pred_taken}, {31'd0, pchk[0]});
        end
        @(posedge clk); #1;
        ex_valid = 1'b0;
        if (m) begin
            @(posedge clk); #1;
            chk("redirect_consumed", exp_q.size(), 32'd0);
        end
    endtask

    task automatic chk_cnt(input string name, input int b, input int m);
        chk({name, "_branch_cnt"}, {{(32-CNT_W){1'b0}}, branch_cnt}, b);
        chk({name, "_mispred_cnt"}, {{(32-CNT_W){1'b0}}, mispred_cnt}, m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] br_codes[5];
        logic [3:0] nb_codes[4];
        br_codes = '{4'b1001, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
        nb_codes = '{4'b1010, 4'b1011, 4'b0000, 4'b0111};

        rst_n = 1'b0; stall = 1'b0;
        if_valid = 1'b0; if_is_branch = 1'b0; if_pc = 32'd0;
        ex_valid = 1'b0; ex_bj_inst = 4'd0; ex_branch = 1'b0;
        ex_pred_taken = 1'b0; ex_pc = 32'd0; ex_target = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_flush_if_id", {31'd0, flush_if_id}, 32'd0);
        chk("rst_flush_id_ex", {31'd0, flush_id_ex}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk_cnt("rst", 0, 0);
        rst_n = 1'b1;

        // 1: every counter reset to weakly not-taken
        if_valid = 1'b1; if_is_branch = 1'b1;
        for (int i = 0; i < BHT_ENTRIES; i++) begin
            if_pc = i * 4;
            #1;
            chk("rst_pred", {31'd0, pred_taken}, 32'd0);
        end
        @(posedge clk); #1;

        // 2: three taken at 0x100 (idx 0); first one mispredicts
        if_pc = 32'h100;
        issue(32'h100, 1'b1, 1'b0, 32'h180, 4'b1000, 0);
        chk("pred_after_first", {31'd0, pred_taken}, 32'd1);
        issue(32'h100, 1'b1, 1'b1, 32'h180, 4'b1000, 1);
        issue(32'h100, 1'b1, 1'b1, 32'h180, 4'b1000, 1);
        chk("pred_saturated", {31'd0, pred_taken}, 32'd1);
        chk_cnt("t2", 3, 1);
        if_valid = 1'b0; #1;
        chk("pred_qual_valid", {31'd0, pred_taken}, 32'd0);
        if_valid = 1'b1; if_is_branch = 1'b0; #1;
        chk("pred_qual_branch", {31'd0, pred_taken}, 32'd0);
        if_is_branch = 1'b1;

        // 3: taken mispredict at 0x200 -> redirect 0x340 for one cycle
        issue(32'h200, 1'b1, 1'b0, 32'h340, 4'b1001, -1);
        chk_cnt("t3", 4, 2);

        // 4: not-taken mispredict at top of address space -> wraps to 0
        issue(32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1234, 4'b1100, -1);
        chk_cnt("t4", 5, 3);
        if_pc = 32'hFC; #1;
        chk("pred_idx63", {31'd0, pred_taken}, 32'd0);

        // Remaining branch codes, correctly predicted not-taken at 0x3C
        for (int i = 0; i < 5; i++) issue(32'h3C, 1'b0, 1'b0, 32'h0, br_codes[i], -1);
        chk_cnt("br_codes", 10, 3);

        // Non-branch codes: no training, no stats, no redirect
        for (int i = 0; i < 4; i++) issue(32'h3C, 1'b1, 1'b0, 32'h500, nb_codes[i], -1);
        chk_cnt("nb_codes", 10, 3);
        if_pc = 32'h3C; #1;
        chk("pred_nb_untrained", {31'd0, pred_taken}, 32'd0);

        // Stall in IDLE blocks training, stats and mispredict
        stall = 1'b1;
        issue(32'h3C, 1'b1, 1'b0, 32'h600, 4'b1000, -1);
        stall = 1'b0;
        chk_cnt("stall_idle", 10, 3);
        #1;
        chk("pred_stall_untrained", {31'd0, pred_taken}, 32'd0);

        // 5: mispredict then 3 stalled FLUSH cycles with a wrong-path branch
        ex_pc = 32'h80; ex_branch = 1'b0; ex_pred_taken = 1'b1;
        ex_target = 32'h0; ex_bj_inst = 4'b1000; ex_valid = 1'b1;
        repeat (4) exp_q.push_back(32'h84);
        @(posedge clk); #1;
        stall = 1'b1;
        ex_pc = 32'h40; ex_branch = 1'b1; ex_pred_taken = 1'b0; ex_target = 32'h999;
        repeat (3) begin @(posedge clk); #1; end
        stall = 1'b0;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("stall_flush_consumed", exp_q.size(), 32'd0);
        chk("stall_flush_dropped", {31'd0, redirect}, 32'd0);
        chk_cnt("t5", 11, 4);
        if_pc = 32'h40; #1;
        chk("pred_wrong_path_untrained", {31'd0, pred_taken}, 32'd0);

        // 6: async reset in the middle of a FLUSH
        ex_pc = 32'h10; ex_branch = 1'b1; ex_pred_taken = 1'b0;
        ex_target = 32'h700; ex_bj_inst = 4'b1000; ex_valid = 1'b1;
        exp_q.push_back(32'h700);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b0; #1;
        chk("midflush_redirect", {31'd0, redirect}, 32'd0);
        chk("midflush_flush_if_id", {31'd0, flush_if_id}, 32'd0);
        chk("midflush_flush_id_ex", {31'd0, flush_id_ex}, 32'd0);
        chk_cnt("midflush", 0, 0);
        chk("midflush_consumed", exp_q.size(), 32'd0);
        #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // Saturation of the statistics counters
        for (int i = 0; i < (1 << CNT_W) - 1; i++)
            issue(32'h20, 1'b1, 1'b0, 32'h2000, 4'b1000, -1);
        chk_cnt("sat_reach", (1 << CNT_W) - 1, (1 << CNT_W) - 1);
        for (int i = 0; i < 3; i++)
            issue(32'h20, 1'b1, 1'b0, 32'h2000, 4'b1000, -1);
        chk_cnt("sat_hold", (1 << CNT_W) - 1, (1 << CNT_W) - 1);

        repeat (2) @(posedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
